ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_pkg.sv | 19 +
 rtl/ifetch_unit_timer.sv | 29 ++
 rtl/ifetch_unit.sv | 103 ++++++++++
 tb/tb_ifetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state type and boot-time defaults.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] MIPS_NOP     = 32'h0000_0000;

    // Address of the next sequential instruction, wrapping at 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_unit_timer.sv
// Memory-wait timeout counter for the fetch unit.
// Counts cycles spent waiting; o_tc flags the last allowed cycle.
module fetch_timer
#(
    parameter int TIMEOUT_CYC = 16
)
(
    input  logic clk,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [W-1:0] r_cnt;

    // Clear has priority; otherwise count up while enabled.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one memory read per start request,
// latches the instruction and next PC, and traps misalignment/timeout.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int          TIMEOUT_CYC = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic [31:0] pc_in,
    input  logic        flush,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] ir_out,
    output logic [31:0] npc_out,
    output logic        fetch_done,
    output logic        busy,
    output logic        fault
);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_ir;
    logic [31:0] r_npc;
    logic        r_done;

    logic        w_in_wait;
    logic        w_tmr_clr;
    logic        w_tmr_en;
    logic        w_tc;

    assign w_in_wait = (r_state == WAIT);
    assign w_tmr_clr = rst || (r_state != WAIT);
    assign w_tmr_en  = w_in_wait && !imem_ready && !flush;

    fetch_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .o_tc  (w_tc)
    );

    // Fetch FSM with registered instruction, next-PC and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= RESET_PC;
            r_ir    <= MIPS_NOP;
            r_npc   <= next_pc(RESET_PC);
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (fetch_start) begin
                        r_addr <= pc_in;
                        if (pc_in[1:0] == 2'b00) begin
                            r_state <= WAIT;
                        end else begin
                            r_state <= FAULT;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_npc   <= next_pc(r_addr);
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_tc) begin
                        r_state <= FAULT;
                    end
                end
                FAULT: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req   = w_in_wait;
    assign imem_addr  = r_addr;
    assign ir_out     = r_ir;
    assign npc_out    = r_npc;
    assign fetch_done = r_done;
    assign busy       = (r_state != IDLE);
    assign fault      = (r_state == FAULT);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a vector table for the main flow
// plus short hand-written sequences for timeout, wrap and reset.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic [31:0] pc_in;
    logic        flush;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] ir_out;
    logic [31:0] npc_out;
    logic        fetch_done;
    logic        busy;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ifetch_unit #(
        .RESET_PC    (32'h0040_0000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc_in       (pc_in),
        .flush       (flush),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .ir_out      (ir_out),
        .npc_out     (npc_out),
        .fetch_done  (fetch_done),
        .busy        (busy),
        .fault       (fault)
    );

    typedef struct {
        logic        start;
        logic        fl;
        logic        rdy;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_busy;
        logic        e_fault;
        logic        e_done;
        logic [31:0] e_ir;
        logic [31:0] e_npc;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [31:0] pc,
                         input logic fl, input logic rdy,
                         input logic [31:0] rd);
        fetch_start = s;
        pc_in       = pc;
        flush       = fl;
        imem_ready  = rdy;
        imem_rdata  = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_req,
                           input logic e_busy, input logic e_fault,
                           input logic e_done, input logic [31:0] e_ir,
                           input logic [31:0] e_npc,
                           input logic [31:0] e_addr);
        chk({tag, ".req"},   {31'd0, imem_req},   {31'd0, e_req});
        chk({tag, ".busy"},  {31'd0, busy},       {31'd0, e_busy});
        chk({tag, ".fault"}, {31'd0, fault},      {31'd0, e_fault});
        chk({tag, ".done"},  {31'd0, fetch_done}, {31'd0, e_done});
        chk({tag, ".ir"},    ir_out,              e_ir);
        chk({tag, ".npc"},   npc_out,             e_npc);
        chk({tag, ".addr"},  imem_addr,           e_addr);
    endtask

    initial begin
        //          st  fl  rdy pc            rdata         req bsy flt dn ir            npc           addr
        vecs[0]  = '{1, 0, 0, 32'h0040_0000, 32'h0,        1, 1, 0, 0, 32'h0,        32'h0040_0004, 32'h0040_0000};
        vecs[1]  = '{0, 0, 0, 32'h0,         32'h0,        1, 1, 0, 0, 32'h0,        32'h0040_0004, 32'h0040_0000};
        vecs[2]  = '{0, 0, 1, 32'h0,         32'h2008_0005, 0, 0, 0, 1, 32'h2008_0005, 32'h0040_0004, 32'h0040_0000};
        vecs[3]  = '{0, 0, 0, 32'h0,         32'h0,        0, 0, 0, 0, 32'h2008_0005, 32'h0040_0004, 32'h0040_0000};
        vecs[4]  = '{1, 0, 0, 32'h0040_0002, 32'h0,        0, 1, 1, 0, 32'h2008_0005, 32'h0040_0004, 32'h0040_0002};
        vecs[5]  = '{1, 0, 1, 32'h0040_0010, 32'h5555_AAAA, 0, 1, 1, 0, 32'h2008_0005, 32'h0040_0004, 32'h0040_0002};
        vecs[6]  = '{0, 1, 0, 32'h0,         32'h0,        0, 0, 0, 0, 32'h2008_0005, 32'h0040_0004, 32'h0040_0002};
        vecs[7]  = '{0, 1, 0, 32'h0,         32'h0,        0, 0, 0, 0, 32'h2008_0005, 32'h0040_0004, 32'h0040_0002};
        vecs[8]  = '{1, 1, 0, 32'h0040_0008, 32'h0,        1, 1, 0, 0, 32'h2008_0005, 32'h0040_0004, 32'h0040_0008};
        vecs[9]  = '{0, 1, 1, 32'h0,         32'hAAAA_5555, 0, 0, 0, 0, 32'h2008_0005, 32'h0040_0004, 32'h0040_0008};
        vecs[10] = '{1, 0, 0, 32'h0040_000C, 32'h0,        1, 1, 0, 0, 32'h2008_0005, 32'h0040_0004, 32'h0040_000C};
        vecs[11] = '{0, 0, 1, 32'h0,         32'h1234_5678, 0, 0, 0, 1, 32'h1234_5678, 32'h0040_0010, 32'h0040_000C};

        // Reset, held against active start/flush.
        rst = 1'b1;
        drive(1, 32'h0000_0100, 1, 1, 32'hFFFF_FFFF);
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 32'h0, 32'h0040_0004, 32'h0040_0000);
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].pc, vecs[i].fl,
                  vecs[i].rdy, vecs[i].rdata);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_req,
                    vecs[i].e_busy, vecs[i].e_fault, vecs[i].e_done,
                    vecs[i].e_ir, vecs[i].e_npc, vecs[i].e_addr);
        end

        // Timeout: ready low for the full 16-cycle window.
        drive(1, 32'h0040_0100, 0, 0, 32'h0);
        step();
        drive(0, 32'h0, 0, 0, 32'h0);
        for (int k = 0; k < 15; k++) begin
            step();
            chk($sformatf("to_wait%0d", k), {29'd0, imem_req, busy, fault},
                32'b110);
        end
        step();
        chk_all("to_fault", 0, 1, 1, 0, 32'h1234_5678,
                32'h0040_0010, 32'h0040_0100);
        drive(0, 32'h0, 1, 0, 32'h0);
        step();
        chk_all("to_flush", 0, 0, 0, 0, 32'h1234_5678,
                32'h0040_0010, 32'h0040_0100);

        // Ready arriving on the last allowed cycle completes normally.
        drive(1, 32'h0040_0100, 0, 0, 32'h0);
        step();
        drive(0, 32'h0, 0, 0, 32'h0);
        for (int k = 0; k < 15; k++) step();
        drive(0, 32'h0, 0, 1, 32'hCAFE_0001);
        step();
        chk_all("to_edge", 0, 0, 0, 1, 32'hCAFE_0001,
                32'h0040_0104, 32'h0040_0100);
        drive(0, 32'h0, 0, 0, 32'h0);
        step();
        chk("to_edge_after.fault", {31'd0, fault}, 32'd0);

        // Next-PC wraps at the top of the address space.
        drive(1, 32'hFFFF_FFFC, 0, 0, 32'h0);
        step();
        drive(0, 32'h0, 0, 1, 32'h0BAD_F00D);
        step();
        chk_all("wrap", 0, 0, 0, 1, 32'h0BAD_F00D,
                32'h0000_0000, 32'hFFFF_FFFC);

        // Reset during WAIT discards the coincident ready.
        drive(1, 32'h0040_0200, 0, 0, 32'h0);
        step();
        chk("rstw.req_pre", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        drive(0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        step();
        chk_all("rstw", 0, 0, 0, 0, 32'h0, 32'h0040_0004, 32'h0040_0000);
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 32'h0);
        step();

        // Start pulses during WAIT are dropped, one fetch completes.
        drive(1, 32'h0040_0300, 0, 0, 32'h0);
        step();
        drive(1, 32'h0040_0400, 0, 0, 32'h0);
        step();
        chk_all("ign1", 1, 1, 0, 0, 32'h0, 32'h0040_0004, 32'h0040_0300);
        drive(1, 32'h0040_0500, 0, 1, 32'h1111_2222);
        step();
        chk_all("ign2", 0, 0, 0, 1, 32'h1111_2222,
                32'h0040_0304, 32'h0040_0300);
        drive(0, 32'h0, 0, 0, 32'h0);
        step();
        chk_all("ign3", 0, 0, 0, 0, 32'h1111_2222,
                32'h0040_0304, 32'h0040_0300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
